swervolf_ram_init: RTL

- AXI4 initiator that fills the main RAM with a deterministic pattern after reset, then optionally reads the whole array back and checks it.
- Sits between the board-level reset and the RAM's AXI responder port. While it runs, it owns the RAM bus.
- Drives the core's i_ram_init_done and i_ram_init_error, which are currently tied to 1 and 0.
- Runs once per reset; the core is released only after o_init_done.

---
 rtl/swervolf_ram_init.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/swervolf_ram_init.sv
// AXI4 initiator that fills the main RAM with a deterministic pattern after reset
// and optionally reads it back to verify, flagging sticky done/error for the core.
module swervolf_ram_init #(
   parameter int unsigned ID_WIDTH   = 6,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned BURST_LEN  = 16,
   parameter logic [63:0] FILL_VALUE = 64'h0,
   parameter bit          ADDR_XOR   = 1'b0,
   parameter bit          CHECK      = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ID_WIDTH-1:0]   o_awid,
   output logic [ADDR_WIDTH-1:0] o_awaddr,
   output logic [7:0]            o_awlen,
   output logic [2:0]            o_awsize,
   output logic [1:0]            o_awburst,
   output logic                  o_awvalid,
   input  logic                  i_awready,
   output logic [63:0]           o_wdata,
   output logic [7:0]            o_wstrb,
   output logic                  o_wlast,
   output logic                  o_wvalid,
   input  logic                  i_wready,
   input  logic [ID_WIDTH-1:0]   i_bid,
   input  logic [1:0]            i_bresp,
   input  logic                  i_bvalid,
   output logic                  o_bready,
   output logic [ID_WIDTH-1:0]   o_arid,
   output logic [ADDR_WIDTH-1:0] o_araddr,
   output logic [7:0]            o_arlen,
   output logic [2:0]            o_arsize,
   output logic [1:0]            o_arburst,
   output logic                  o_arvalid,
   input  logic                  i_arready,
   input  logic [ID_WIDTH-1:0]   i_rid,
   input  logic [63:0]           i_rdata,
   input  logic [1:0]            i_rresp,
   input  logic                  i_rlast,
   input  logic                  i_rvalid,
   output logic                  o_rready,
   output logic                  o_busy,
   output logic                  o_init_done,
   output logic                  o_init_error
);

   // One extra address bit so the last-burst compare never wraps.
   localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
   localparam int unsigned BEAT_W = 8;
   localparam logic [CNT_W-1:0]  BURST_BYTES = CNT_W'(BURST_LEN * 8);
   localparam logic [CNT_W-1:0]  LAST_BASE   = CNT_W'((64'd1 << ADDR_WIDTH) - 64'(BURST_LEN * 8));
   localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);

   typedef enum logic [2:0] {
      WR_ADDR,
      WR_DATA,
      WR_RESP,
      RD_ADDR,
      RD_DATA,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  base_q, base_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              awvalid_q, awvalid_d;
   logic              wvalid_q, wvalid_d;
   logic              wlast_q, wlast_d;
   logic [63:0]       wdata_q, wdata_d;
   logic              bready_q, bready_d;
   logic              arvalid_q, arvalid_d;
   logic              rready_q, rready_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              busy_q, busy_d;
   logic [CNT_W-1:0]  beat_addr;
   logic              last_burst;

   function automatic logic [63:0] pattern(input logic [CNT_W-1:0] addr);
      logic [31:0] a32;
      a32 = 32'(addr[ADDR_WIDTH-1:0]);
      return ADDR_XOR ? (FILL_VALUE ^ {a32, a32}) : FILL_VALUE;
   endfunction

   assign beat_addr  = base_q + (CNT_W'(beat_q) << 3);
   assign last_burst = (base_q == LAST_BASE);

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      beat_d    = beat_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      wlast_d   = wlast_q;
      wdata_d   = wdata_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      done_d    = done_q;
      error_d   = error_q;
      busy_d    = busy_q;

      unique case (state_q)
         WR_ADDR: begin
            awvalid_d = 1'b1;
            if (awvalid_q && i_awready) begin
               awvalid_d = 1'b0;
               wvalid_d  = 1'b1;
               wdata_d   = pattern(base_q);
               wlast_d   = (LAST_BEAT == '0);
               beat_d    = '0;
               state_d   = WR_DATA;
            end
         end
         WR_DATA: begin
            if (wvalid_q && i_wready) begin
               if (beat_q == LAST_BEAT) begin
                  wvalid_d = 1'b0;
                  wlast_d  = 1'b0;
                  bready_d = 1'b1;
                  state_d  = WR_RESP;
               end else begin
                  beat_d  = beat_q + BEAT_W'(1);
                  wdata_d = pattern(beat_addr + CNT_W'(8));
                  wlast_d = ((beat_q + BEAT_W'(1)) == LAST_BEAT);
               end
            end
         end
         WR_RESP: begin
            bready_d = 1'b1;
            if (bready_q && i_bvalid) begin
               bready_d = 1'b0;
               if (i_bresp != 2'b00) error_d = 1'b1;
               if (!last_burst) begin
                  base_d  = base_q + BURST_BYTES;
                  state_d = WR_ADDR;
               end else if (CHECK) begin
                  base_d  = '0;
                  state_d = RD_ADDR;
               end else begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = DONE;
               end
            end
         end
         RD_ADDR: begin
            arvalid_d = 1'b1;
            if (arvalid_q && i_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               beat_d    = '0;
               state_d   = RD_DATA;
            end
         end
         RD_DATA: begin
            if (rready_q && i_rvalid) begin
               if ((i_rdata != pattern(beat_addr)) || (i_rresp != 2'b00) ||
                   (i_rlast != (beat_q == LAST_BEAT)))
                  error_d = 1'b1;
               if (beat_q == LAST_BEAT) begin
                  rready_d = 1'b0;
                  if (last_burst) begin
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     state_d = DONE;
                  end else begin
                     base_d  = base_q + BURST_BYTES;
                     state_d = RD_ADDR;
                  end
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         DONE: begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            done_d    = 1'b1;
            busy_d    = 1'b0;
         end
         default: state_d = WR_ADDR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= WR_ADDR;
         base_q    <= '0;
         beat_q    <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         wlast_q   <= 1'b0;
         wdata_q   <= '0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         beat_q    <= beat_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         wlast_q   <= wlast_d;
         wdata_q   <= wdata_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         done_q    <= done_d;
         error_q   <= error_d;
         busy_q    <= busy_d;
      end
   end

   assign o_awid       = '0;
   assign o_awaddr     = base_q[ADDR_WIDTH-1:0];
   assign o_awlen      = 8'(BURST_LEN - 1);
   assign o_awsize     = 3'd3;
   assign o_awburst    = 2'b01;
   assign o_awvalid    = awvalid_q;
   assign o_wdata      = wdata_q;
   assign o_wstrb      = 8'hFF;
   assign o_wlast      = wlast_q;
   assign o_wvalid     = wvalid_q;
   assign o_bready     = bready_q;
   assign o_arid       = '0;
   assign o_araddr     = base_q[ADDR_WIDTH-1:0];
   assign o_arlen      = 8'(BURST_LEN - 1);
   assign o_arsize     = 3'd3;
   assign o_arburst    = 2'b01;
   assign o_arvalid    = arvalid_q;
   assign o_rready     = rready_q;
   assign o_busy       = busy_q;
   assign o_init_done  = done_q;
   assign o_init_error = error_q;

   // Response IDs carry no information since only ID 0 is ever issued.
   logic unused_ids;
   assign unused_ids = ^{i_bid, i_rid};

endmodule
